// File: rtl/match_controller_pkg.sv
// Shared types for the match controller: state encoding, winner codes and round limit.
package match_pkg;

   typedef enum logic [2:0] {
      ST_IDLE       = 3'd0,
      ST_COUNTDOWN  = 3'd1,
      ST_FIGHT      = 3'd2,
      ST_KO         = 3'd3,
      ST_MATCH_OVER = 3'd4
   } match_state_t;

   typedef enum logic [1:0] {
      WIN_NONE = 2'b00,
      WIN_P1   = 2'b01,
      WIN_P2   = 2'b10,
      WIN_DRAW = 2'b11
   } winner_t;

   localparam logic [2:0] MAX_ROUND = 3'd7;

   function automatic winner_t compare_score(input logic [3:0] a, input logic [3:0] b);
      if (a > b)      return WIN_P1;
      else if (b > a) return WIN_P2;
      else            return WIN_DRAW;
   endfunction

endpackage

// File: rtl/match_controller_if.sv
// Start/health inputs and status outputs between the match controller and the game core.
interface match_controller_if;
   logic       start_btn;
   logic [3:0] p1_health;
   logic [3:0] p2_health;
   logic       game_rst_n;
   logic       inputs_enable;
   logic [2:0] match_state;
   logic [6:0] timer_s;
   logic [1:0] p1_rounds;
   logic [1:0] p2_rounds;
   logic [2:0] round_num;
   logic [1:0] winner;

   modport master (
      input  start_btn, p1_health, p2_health,
      output game_rst_n, inputs_enable, match_state, timer_s,
             p1_rounds, p2_rounds, round_num, winner
   );

   modport slave (
      output start_btn, p1_health, p2_health,
      input  game_rst_n, inputs_enable, match_state, timer_s,
             p1_rounds, p2_rounds, round_num, winner
   );
endinterface

// File: rtl/match_controller_sec_tick.sv
// One-second tick generator; restart realigns the second boundary to a state entry.
module sec_tick #(
   parameter int unsigned CLK_HZ = 100_000_000
) (
   input  logic clk,
   input  logic reset,
   input  logic restart,
   output logic tick
);
   localparam int unsigned   CW   = (CLK_HZ > 1) ? $clog2(CLK_HZ) : 1;
   localparam logic [CW-1:0] LAST = CW'(CLK_HZ - 1);

   logic [CW-1:0] cnt;

   assign tick = (cnt == LAST);

   always_ff @(posedge clk or negedge reset) begin
      if (!reset)               cnt <= '0;
      else if (restart || tick) cnt <= '0;
      else                      cnt <= cnt + 1'b1;
   end
endmodule

// File: rtl/match_controller.sv
// Fighting-game match sequencer: countdown, timed rounds, KO hold and best-of scoring.
module match_controller
   import match_pkg::*;
#(
   parameter int unsigned CLK_HZ        = 100_000_000,
   parameter int unsigned COUNTDOWN_S   = 3,
   parameter int unsigned ROUND_S       = 60,
   parameter int unsigned KO_HOLD_S     = 2,
   parameter int unsigned ROUNDS_TO_WIN = 2
) (
   input logic                clk,
   input logic                reset,
   match_controller_if.master bus
);
   localparam logic [6:0] CD_LOAD = 7'(COUNTDOWN_S);
   localparam logic [6:0] RS_LOAD = 7'(ROUND_S);
   localparam logic [6:0] KH_LOAD = 7'(KO_HOLD_S);
   localparam logic [1:0] WIN_CNT = 2'(ROUNDS_TO_WIN);

   match_state_t state, next_state;
   winner_t      win, win_d, round_res;
   logic         start_q, start_edge, tick, entering, timer_last;
   logic [6:0]   timer, timer_d;
   logic [1:0]   p1r, p1r_d, p2r, p2r_d;
   logic [2:0]   rnum, rnum_d;
   logic         ie, ie_d, grst, grst_d;

   assign start_edge = bus.start_btn & ~start_q;
   assign timer_last = tick && (timer <= 7'd1);
   assign entering   = (next_state != state);
   // The zero-health rules (lone zero loses, double zero draws) coincide with a plain health comparison.
   assign round_res  = compare_score(bus.p1_health, bus.p2_health);

   sec_tick #(.CLK_HZ(CLK_HZ)) u_sec_tick (
      .clk     (clk),
      .reset   (reset),
      .restart (entering),
      .tick    (tick)
   );

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) state <= ST_IDLE;
      else        state <= next_state;
   end

   always_comb begin
      next_state = state;
      case (state)
         ST_IDLE:       if (start_edge) next_state = ST_COUNTDOWN;
         ST_COUNTDOWN:  if (timer_last) next_state = ST_FIGHT;
         ST_FIGHT:      if (bus.p1_health == '0 || bus.p2_health == '0 || timer_last)
                           next_state = ST_KO;
         ST_KO:         if (timer_last) begin
                           if (p1r == WIN_CNT || p2r == WIN_CNT || rnum == MAX_ROUND)
                              next_state = ST_MATCH_OVER;
                           else
                              next_state = ST_COUNTDOWN;
                        end
         ST_MATCH_OVER: if (start_edge) next_state = ST_COUNTDOWN;
         default:       next_state = ST_IDLE;
      endcase
   end

   always_comb begin
      timer_d = timer;
      p1r_d   = p1r;
      p2r_d   = p2r;
      rnum_d  = rnum;
      win_d   = win;
      ie_d    = (state == ST_FIGHT) && (next_state == ST_FIGHT);
      grst_d  = !(entering && next_state == ST_COUNTDOWN);
      if (tick && timer != '0) timer_d = timer - 7'd1;
      if (entering) begin
         case (next_state)
            ST_COUNTDOWN: begin
               timer_d = CD_LOAD;
               if (state == ST_KO) begin
                  rnum_d = rnum + 3'd1;
               end else begin
                  p1r_d  = '0;
                  p2r_d  = '0;
                  win_d  = WIN_NONE;
                  rnum_d = 3'd1;
               end
            end
            ST_FIGHT: timer_d = RS_LOAD;
            ST_KO: begin
               timer_d = KH_LOAD;
               if (round_res == WIN_P1 && p1r != WIN_CNT) p1r_d = p1r + 2'd1;
               if (round_res == WIN_P2 && p2r != WIN_CNT) p2r_d = p2r + 2'd1;
            end
            ST_MATCH_OVER: win_d = compare_score({2'b00, p1r}, {2'b00, p2r});
            default: ;
         endcase
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         start_q <= 1'b0;
         timer   <= '0;
         p1r     <= '0;
         p2r     <= '0;
         rnum    <= '0;
         win     <= WIN_NONE;
         ie      <= 1'b0;
         grst    <= 1'b0;
      end else begin
         start_q <= bus.start_btn;
         timer   <= timer_d;
         p1r     <= p1r_d;
         p2r     <= p2r_d;
         rnum    <= rnum_d;
         win     <= win_d;
         ie      <= ie_d;
         grst    <= grst_d;
      end
   end

   assign bus.game_rst_n    = grst;
   assign bus.inputs_enable = ie;
   assign bus.match_state   = state;
   assign bus.timer_s       = timer;
   assign bus.p1_rounds     = p1r;
   assign bus.p2_rounds     = p2r;
   assign bus.round_num     = rnum;
   assign bus.winner        = win;
endmodule

// File: tb/tb_match_controller.sv
// Directed/randomised bench for match_controller against a round-level scoring and timing model.
module tb_match_controller;
   localparam int unsigned CLK  = 10;
   localparam int unsigned CD_S = 3;
   localparam int unsigned RN_S = 5;
   localparam int unsigned KH_S = 2;
   localparam int unsigned RTW  = 2;

   logic clk;
   logic reset;
   int unsigned checks = 0;
   int unsigned errors = 0;

   int unsigned m_p1r, m_p2r, m_round, m_winner;
   bit          m_over;

   match_controller_if bus ();

   match_controller #(
      .CLK_HZ        (CLK),
      .COUNTDOWN_S   (CD_S),
      .ROUND_S       (RN_S),
      .KO_HOLD_S     (KH_S),
      .ROUNDS_TO_WIN (RTW)
   ) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic step(input int unsigned n);
      if (n != 0) begin
         repeat (n) @(posedge clk);
         #1;
      end
   endtask

   task automatic chk(input string tag, input int unsigned obs, input int unsigned exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   // Round outcome straight from the rules: lone zero loses, double zero draws, else higher health.
   function automatic int unsigned exp_round_winner(input int unsigned h1, input int unsigned h2);
      if (h1 == 0 && h2 == 0) return 3;
      if (h2 == 0)            return 1;
      if (h1 == 0)            return 2;
      if (h1 > h2)            return 1;
      if (h2 > h1)            return 2;
      return 3;
   endfunction

   function automatic int unsigned exp_match_winner(input int unsigned a, input int unsigned b);
      if (a > b) return 1;
      if (b > a) return 2;
      return 3;
   endfunction

   task automatic chk_reset_vals(input string pfx);
      chk({pfx, "_state"},      32'(bus.match_state),   0);
      chk({pfx, "_game_rst_n"}, 32'(bus.game_rst_n),    0);
      chk({pfx, "_inputs_en"},  32'(bus.inputs_enable), 0);
      chk({pfx, "_timer"},      32'(bus.timer_s),       0);
      chk({pfx, "_p1_rounds"},  32'(bus.p1_rounds),     0);
      chk({pfx, "_p2_rounds"},  32'(bus.p2_rounds),     0);
      chk({pfx, "_round_num"},  32'(bus.round_num),     0);
      chk({pfx, "_winner"},     32'(bus.winner),        0);
   endtask

   task automatic start_match();
      bus.start_btn = 1'b1;
      step(1);
      bus.start_btn = 1'b0;
      m_p1r = 0; m_p2r = 0; m_round = 1; m_winner = 0; m_over = 0;
   endtask

   // Entered one step after COUNTDOWN entry; leaves one step after KO expiry.
   task automatic play_round(input bit timeout, input int unsigned h1, input int unsigned h2,
                             input bit hold_start);
      int unsigned d;
      chk("cd_state",      32'(bus.match_state), 1);
      chk("cd_game_rst",   32'(bus.game_rst_n),  0);
      chk("cd_timer",      32'(bus.timer_s),     CD_S);
      chk("cd_round",      32'(bus.round_num),   m_round);
      chk("cd_p1_rounds",  32'(bus.p1_rounds),   m_p1r);
      chk("cd_p2_rounds",  32'(bus.p2_rounds),   m_p2r);
      chk("cd_winner",     32'(bus.winner),      m_winner);
      chk("cd_inputs_en",  32'(bus.inputs_enable), 0);
      step(1);
      chk("cd_game_rst_release", 32'(bus.game_rst_n), 1);
      bus.start_btn = 1'b1;
      step(1);
      bus.start_btn = 1'b0;
      bus.p1_health = 4'($urandom_range(0, 15));
      bus.p2_health = 4'($urandom_range(0, 15));
      step(CD_S * CLK - 4);
      chk("cd_last_state", 32'(bus.match_state), 1);
      chk("cd_last_timer", 32'(bus.timer_s),     1);
      bus.p1_health = 4'd15;
      bus.p2_health = 4'd15;
      step(2);
      chk("fight_state",   32'(bus.match_state),   2);
      chk("fight_timer",   32'(bus.timer_s),       RN_S);
      chk("fight_ie_lag",  32'(bus.inputs_enable), 0);
      step(1);
      chk("fight_ie",      32'(bus.inputs_enable), 1);
      if (timeout) begin
         bus.p1_health = 4'(h1);
         bus.p2_health = 4'(h2);
         step(RN_S * CLK - 2);
         chk("fight_last_state", 32'(bus.match_state), 2);
         chk("fight_last_timer", 32'(bus.timer_s),     1);
         step(1);
      end else begin
         d = $urandom_range(0, RN_S * CLK - 3);
         step(d);
         chk("fight_pre_hit", 32'(bus.match_state), 2);
         bus.p1_health = 4'(h1);
         bus.p2_health = 4'(h2);
         step(1);
      end
      case (exp_round_winner(h1, h2))
         1: if (m_p1r < RTW) m_p1r++;
         2: if (m_p2r < RTW) m_p2r++;
         default: ;
      endcase
      chk("ko_state",     32'(bus.match_state),   3);
      chk("ko_timer",     32'(bus.timer_s),       KH_S);
      chk("ko_inputs_en", 32'(bus.inputs_enable), 0);
      chk("ko_p1_rounds", 32'(bus.p1_rounds),     m_p1r);
      chk("ko_p2_rounds", 32'(bus.p2_rounds),     m_p2r);
      bus.p1_health = 4'($urandom_range(0, 15));
      bus.p2_health = 4'($urandom_range(0, 15));
      bus.start_btn = 1'b1;
      step(1);
      if (!hold_start) bus.start_btn = 1'b0;
      step(KH_S * CLK - 2);
      chk("ko_last_state",     32'(bus.match_state), 3);
      chk("ko_last_timer",     32'(bus.timer_s),     1);
      chk("ko_last_p1_rounds", 32'(bus.p1_rounds),   m_p1r);
      chk("ko_last_p2_rounds", 32'(bus.p2_rounds),   m_p2r);
      step(1);
      m_over = (m_p1r == RTW) || (m_p2r == RTW) || (m_round == 7);
      if (m_over) begin
         m_winner = exp_match_winner(m_p1r, m_p2r);
         chk("over_state",  32'(bus.match_state), 4);
         chk("over_winner", 32'(bus.winner),      m_winner);
         chk("over_round",  32'(bus.round_num),   m_round);
      end else begin
         m_round++;
         chk("next_round_state", 32'(bus.match_state), 1);
      end
   endtask

   initial begin
      int unsigned h;
      int unsigned pick;
      reset         = 1'b1;
      bus.start_btn = 1'b0;
      bus.p1_health = 4'd15;
      bus.p2_health = 4'd15;
      #2 reset = 1'b0;
      #1 chk_reset_vals("por");
      step(3);
      chk_reset_vals("por_held");
      reset = 1'b1;
      step(5);
      chk("idle_state",      32'(bus.match_state), 0);
      chk("idle_game_rst_n", 32'(bus.game_rst_n),  1);

      // Match 1: KO win, timeout loss, double-KO draw, then a timeout win with start held high.
      start_match();
      play_round(1'b0, 15, 0, 1'b0);
      play_round(1'b1, 9, 12, 1'b0);
      play_round(1'b0, 0, 0, 1'b0);
      play_round(1'b1, 12, 3, 1'b1);
      step(15);
      chk("held_start_state",  32'(bus.match_state), 4);
      chk("held_start_winner", 32'(bus.winner),      1);
      bus.start_btn = 1'b0;
      step(2);

      // Match 2: seven draws in a row end on the round limit.
      start_match();
      for (int i = 0; i < 7; i++) begin
         h = $urandom_range(1, 15);
         if (i % 2 == 1) play_round(1'b1, h, h, 1'b0);
         else            play_round(1'b0, 0, 0, 1'b0);
      end
      chk("draw_match_over", 32'(m_over), 1);
      step(3);

      // Match 3: random rounds.
      start_match();
      for (int r = 0; r < 7 && !m_over; r++) begin
         if ($urandom_range(0, 1) == 1) begin
            h    = $urandom_range(1, 15);
            pick = ($urandom_range(0, 3) == 0) ? h : $urandom_range(1, 15);
            play_round(1'b1, h, pick, 1'b0);
         end else begin
            pick = $urandom_range(0, 2);
            if (pick == 0)      play_round(1'b0, 0, $urandom_range(1, 15), 1'b0);
            else if (pick == 1) play_round(1'b0, $urandom_range(1, 15), 0, 1'b0);
            else                play_round(1'b0, 0, 0, 1'b0);
         end
      end
      step(3);

      // Reset mid-fight, with a lethal hit arriving at the same moment.
      bus.p1_health = 4'd15;
      bus.p2_health = 4'd15;
      start_match();
      step(CD_S * CLK);
      chk("abort_fight_state", 32'(bus.match_state), 2);
      step(5);
      bus.p2_health = 4'd0;
      #2 reset = 1'b0;
      #1 chk_reset_vals("abort");
      step(2);
      reset = 1'b1;
      bus.p2_health = 4'd15;
      step(CD_S * CLK);
      chk("abort_idle_state",  32'(bus.match_state), 0);
      chk("abort_idle_rounds", 32'(bus.p1_rounds),   0);
      chk("abort_idle_timer",  32'(bus.timer_s),     0);
      chk("abort_idle_round",  32'(bus.round_num),   0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
